// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter through a one-cycle send_en handshake.
// Define UART_TX_FIFO_GAP_EN to insert GAP_CYCLES idle cycles after every frame.
module uart_tx_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned GAP_CYCLES = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic [7:0]               data_byte_tx,
  output logic                     send_en,
  input  logic                     tx_done,
  input  logic                     uart_state
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0) || (GAP_CYCLES == 0))
  begin : g_param_check
    $error("uart_tx_fifo: DEPTH must be a power of two in 2..256, GAP_CYCLES >= 1");
  end

`ifdef UART_TX_FIFO_GAP_EN
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StWait = 2'd2,
    StGap  = 2'd3
  } state_e;
  logic [GW-1:0] r_gap_cnt;
`else
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StWait = 2'd2
  } state_e;
`endif

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic [7:0]    r_data;
  logic          r_send_en;
  state_e        r_state;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Outputs decode registers only; no input reaches an output combinationally.
  assign w_full       = (r_count == CW'(DEPTH));
  assign w_empty      = (r_count == '0);
  assign full         = w_full;
  assign empty        = w_empty;
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign data_byte_tx = r_data;
  assign send_en      = r_send_en;

  // Fullness is judged before any same-cycle pop, so a write at count == DEPTH is dropped.
  assign w_push = wr_en && !w_full && !rst;
  assign w_pop  = (r_state == StIdle) && !w_empty && !uart_state;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (wr_en && w_full) r_overflow <= 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= StIdle;
      r_data    <= 8'h00;
      r_send_en <= 1'b0;
`ifdef UART_TX_FIFO_GAP_EN
      r_gap_cnt <= '0;
`endif
    end else begin
      r_send_en <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_pop) begin
            r_data    <= r_mem[r_rd_ptr];
            r_send_en <= 1'b1;
            r_state   <= StSend;
          end
        end
        StSend: r_state <= StWait;
        StWait: begin
          if (tx_done) begin
`ifdef UART_TX_FIFO_GAP_EN
            r_gap_cnt <= '0;
            r_state   <= StGap;
`else
            r_state   <= StIdle;
`endif
          end
        end
`ifdef UART_TX_FIFO_GAP_EN
        StGap: begin
          if (r_gap_cnt == GW'(GAP_CYCLES - 1)) begin
            r_state <= StIdle;
          end else begin
            r_gap_cnt <= r_gap_cnt + 1'b1;
          end
        end
`endif
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised scoreboard bench for uart_tx_fifo: a queue-based reference model predicts
// FIFO contents and send pulses, and a negedge monitor checks every DUT output.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int GAP   = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_done = 1'b0;
  logic       tx_busy = 1'b0;
  logic       hold_busy = 1'b0;
  logic       uart_state;
  logic       full;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic [7:0] data_byte_tx;
  logic       send_en;

  assign uart_state = tx_busy | hold_busy;

  uart_tx_fifo #(
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .full         (full),
    .empty        (empty),
    .count        (count),
    .overflow     (overflow),
    .data_byte_tx (data_byte_tx),
    .send_en      (send_en),
    .tx_done      (tx_done),
    .uart_state   (uart_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(input string nm, input int act, input int want);
    n_tests++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, want, $time);
    end
  endfunction

  // Reference model: stored bytes, bytes awaiting their send pulse, and frame phase
  // (0 idle, 1 pulse cycle, 2 awaiting tx_done, 3 inter-frame gap).
  logic [7:0] m_q[$];
  logic [7:0] exp_q[$];
  bit         m_ovf = 1'b0;
  logic [7:0] m_last = 8'h00;
  int         m_phase = 0;
  bit         m_send = 1'b0;
  int         m_gap = 0;
  bit         m_was_full;
  bit         m_pop;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_q.delete();
      exp_q.delete();
      m_ovf   = 1'b0;
      m_last  = 8'h00;
      m_phase = 0;
      m_gap   = 0;
      m_send  = 1'b0;
    end else begin
      m_was_full = (m_q.size() == DEPTH);
      m_pop      = (m_phase == 0) && (m_q.size() != 0) && !uart_state;
      if (wr_en && m_was_full) m_ovf = 1'b1;
      case (m_phase)
        0: if (m_pop) m_phase = 1;
        1: m_phase = 2;
        2: if (tx_done) begin
`ifdef UART_TX_FIFO_GAP_EN
          m_phase = 3;
          m_gap   = 0;
`else
          m_phase = 0;
`endif
        end
        default: begin
          m_gap++;
          if (m_gap == GAP) m_phase = 0;
        end
      endcase
      if (m_pop) begin
        m_last = m_q.pop_front();
        exp_q.push_back(m_last);
      end
      if (wr_en && !m_was_full) m_q.push_back(wr_data);
      m_send = (m_phase == 1);
    end
  end

  // Monitor: compares outputs mid-cycle and retires one expected byte per send pulse.
  initial forever begin
    @(negedge clk);
    check("count", count, m_q.size());
    check("empty", empty, m_q.size() == 0);
    check("full", full, m_q.size() == DEPTH);
    check("overflow", overflow, m_ovf);
    check("send_en", send_en, m_send);
    check("data_hold", data_byte_tx, m_last);
    if (send_en) begin
      check("send_has_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("send_data", data_byte_tx, exp_q.pop_front());
    end
  end

  // Transmitter stand-in: busy for a random frame length after each send pulse.
  int tx_lo = 1;
  int tx_hi = 6;
  int tx_left = 0;
  bit spur_en = 1'b0;

  initial forever begin
    @(negedge clk);
    tx_done = 1'b0;
    if (tx_busy) begin
      if (tx_left == 0) begin
        tx_busy = 1'b0;
        tx_done = 1'b1;
      end else begin
        tx_left--;
      end
    end else if (send_en) begin
      tx_busy = 1'b1;
      tx_left = $urandom_range(tx_hi, tx_lo);
    end else if (spur_en && ($urandom_range(15, 0) == 0)) begin
      tx_done = 1'b1;
    end
  end

  task automatic tick(input logic we, input logic [7:0] d);
    @(negedge clk);
    wr_en   = we;
    wr_data = d;
  endtask

  task automatic drain();
    int n;
    n = 0;
    tick(1'b0, 8'h00);
    hold_busy = 1'b0;
    while ((m_q.size() != 0 || m_phase != 0 || tx_busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_bound", n < 3000, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Reset held 5 cycles with a write strobe that must be ignored.
    rst     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 8'h77;
    repeat (5) @(negedge clk);
    rst   = 1'b0;
    wr_en = 1'b0;
    check("reset_count_zero", count, 0);

    // Single byte, then a three-byte ordered burst.
    tick(1'b1, 8'hAA);
    drain();
    tick(1'b1, 8'hAA);
    tick(1'b1, 8'h55);
    tick(1'b1, 8'h0F);
    drain();
    check("order_end_empty", empty, 1);

    // Fill to DEPTH with the transmitter held busy; the extra write is dropped.
    hold_busy = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick(1'b1, 8'(i + 1));
    tick(1'b0, 8'h00);
    check("full_count", count, DEPTH);
    check("full_overflow", overflow, 1);
    repeat (3) @(negedge clk);
    drain();

    // Write and pop on the same edge at count == DEPTH, then keep writing while draining.
    hold_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) tick(1'b1, 8'(8'h40 + i));
    @(negedge clk);
    hold_busy = 1'b0;
    wr_en     = 1'b1;
    wr_data   = 8'hEE;
    for (int i = 0; i < 19; i++) tick(1'b1, 8'($urandom));
    drain();

    // Reset while awaiting tx_done with three bytes queued.
    tx_lo = 12;
    tx_hi = 12;
    tick(1'b1, 8'hA1);
    tick(1'b1, 8'hB2);
    tick(1'b1, 8'hC3);
    tick(1'b1, 8'hD4);
    tick(1'b0, 8'h00);
    check("pre_reset_count", count, 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drain();
    tx_lo = 1;
    tx_hi = 6;

    // Random traffic with stray tx_done, busy holds and occasional resets.
    spur_en = 1'b1;
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      wr_en   = ($urandom_range(99, 0) < 40);
      wr_data = 8'($urandom);
      rst     = ($urandom_range(299, 0) == 0);
      if ($urandom_range(99, 0) == 0) hold_busy = !hold_busy;
    end
    @(negedge clk);
    rst     = 1'b0;
    spur_en = 1'b0;
    drain();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach its end, %0d tests run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule
